// File: rtl/sdhci_pkg.sv
// Shared SDHCI definitions.
// Holds the DAT0 busy-monitor state encoding and the CRC status token values.
package sdhci_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StToken,
    StEndBit,
    StGuard,
    StBusy
  } dat_busy_state_e;

  // CRC status token bits as sampled MSB first between the start and end bits.
  localparam logic [2:0] CRC_TOKEN_OK  = 3'b010;
  localparam logic [2:0] CRC_TOKEN_NEG = 3'b101;

endpackage

// File: rtl/dat_busy_monitor_if.sv
// Controller-side handshake of the DAT0 busy monitor.
//   start        controller -> monitor  pulse: begin a monitor sequence
//   busy_only    controller -> monitor  qualifier of start: 1 = R1b busy only
//   abort        controller -> monitor  pulse: drop back to idle, no done
//   active       monitor -> controller  sequence in progress
//   done         monitor -> controller  one-cycle end-of-sequence pulse
//   crc_err      monitor -> controller  with done: negative CRC token
//   token_err    monitor -> controller  with done: framing/token/start-bit error
//   timeout_err  monitor -> controller  with done: dat_timeout expired
//   busy_cycles  monitor -> controller  strobes spent in guard+busy
//                (only when SDHCI_BUSY_CYCLES_EN is defined)
// Modports: master = data/transfer controller, slave = dat_busy_monitor.
interface dat_busy_monitor_if;

  logic start;
  logic busy_only;
  logic abort;
  logic active;
  logic done;
  logic crc_err;
  logic token_err;
  logic timeout_err;
`ifdef SDHCI_BUSY_CYCLES_EN
  logic [31:0] busy_cycles;
`endif

  modport master (
    output start,
    output busy_only,
    output abort,
    input  active,
    input  done,
    input  crc_err,
    input  token_err,
`ifdef SDHCI_BUSY_CYCLES_EN
    input  busy_cycles,
`endif
    input  timeout_err
  );

  modport slave (
    input  start,
    input  busy_only,
    input  abort,
    output active,
    output done,
    output crc_err,
    output token_err,
`ifdef SDHCI_BUSY_CYCLES_EN
    output busy_cycles,
`endif
    output timeout_err
  );

endinterface

// File: rtl/dat_busy_monitor.sv
// DAT0 busy monitor: after a block write receives the CRC status token
// (start bit, 3 token bits, end bit) and then waits out card busy; in R1b mode
// only waits out busy. Drives the running input of dat_timeout and consumes its
// timeout.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   sd_strobe_i  one-cycle strobe: sample DAT0 this cycle
//   dat0_i       synchronised DAT0 level
//   running_o    to dat_timeout: waiting for the card
//   timeout_i    from dat_timeout
//   ctrl_if      controller handshake (dat_busy_monitor_if.slave)
// Optional feature: SDHCI_BUSY_CYCLES_EN adds ctrl_if.busy_cycles, a saturating
// count of strobes spent in guard+busy, cleared on an accepted start.
module dat_busy_monitor
  import sdhci_pkg::*;
#(
  parameter int unsigned BusyGuard    = 2,  // >= 1
  parameter int unsigned TokenWaitMax = 8   // >= 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sd_strobe_i,
  input  logic                   dat0_i,
  output logic                   running_o,
  input  logic                   timeout_i,
  dat_busy_monitor_if.slave      ctrl_if
);

  // The counter is shared by start-bit wait, token bits and guard.
  localparam int unsigned CntMax0 = (BusyGuard > TokenWaitMax) ? BusyGuard : TokenWaitMax;
  localparam int unsigned CntMax  = (CntMax0 > 3) ? CntMax0 : 3;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] WaitLast  = CntW'(TokenWaitMax - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(BusyGuard - 1);
  localparam logic [CntW-1:0] TokLast   = CntW'(2);
  localparam logic [CntW-1:0] CntSat    = CntW'(CntMax);

  dat_busy_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      tok_q, tok_d;
  logic            done_q, done_d;
  logic            crc_err_q, crc_err_d;
  logic            token_err_q, token_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic [CntW-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tok_d         = tok_q;
    done_d        = 1'b0;
    crc_err_d     = 1'b0;
    token_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    if (ctrl_if.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (state_q != StIdle && timeout_i) begin
      // Timeout outranks any DAT0 event sampled in the same cycle.
      state_d       = StIdle;
      cnt_d         = '0;
      done_d        = 1'b1;
      timeout_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_if.start) begin
            cnt_d   = '0;
            state_d = ctrl_if.busy_only ? StGuard : StWaitStart;
          end
        end
        StWaitStart: begin
          if (sd_strobe_i) begin
            if (!dat0_i) begin
              state_d = StToken;
              cnt_d   = '0;
            end else if (cnt_q >= WaitLast) begin
              state_d     = StIdle;
              cnt_d       = '0;
              done_d      = 1'b1;
              token_err_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StToken: begin
          if (sd_strobe_i) begin
            tok_d = {tok_q[1:0], dat0_i};
            if (cnt_q >= TokLast) begin
              state_d = StEndBit;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StEndBit: begin
          if (sd_strobe_i) begin
            cnt_d = '0;
            // A missing end bit is a framing error regardless of token value.
            if (dat0_i && tok_q == CRC_TOKEN_OK) begin
              state_d = StGuard;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
              if (dat0_i && tok_q == CRC_TOKEN_NEG) begin
                crc_err_d = 1'b1;
              end else begin
                token_err_d = 1'b1;
              end
            end
          end
        end
        StGuard: begin
          // DAT0 is deliberately not looked at: the card may not pull it low yet.
          if (sd_strobe_i) begin
            if (cnt_q >= GuardLast) begin
              state_d = StBusy;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StBusy: begin
          if (sd_strobe_i && dat0_i) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      tok_q         <= '0;
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      token_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tok_q         <= tok_d;
      done_q        <= done_d;
      crc_err_q     <= crc_err_d;
      token_err_q   <= token_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign running_o           = (state_q != StIdle);
  assign ctrl_if.active      = (state_q != StIdle);
  assign ctrl_if.done        = done_q;
  assign ctrl_if.crc_err     = crc_err_q;
  assign ctrl_if.token_err   = token_err_q;
  assign ctrl_if.timeout_err = timeout_err_q;

`ifdef SDHCI_BUSY_CYCLES_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (state_q == StIdle && ctrl_if.start && !ctrl_if.abort) begin
      busy_cycles_d = '0;
    end else if ((state_q == StGuard || state_q == StBusy) && sd_strobe_i &&
                 busy_cycles_q != 32'hFFFF_FFFF) begin
      busy_cycles_d = busy_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_cycles_q <= '0;
    end else begin
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign ctrl_if.busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_dat_busy_monitor.sv
// Directed self-checking bench for dat_busy_monitor (BusyGuard=2, TokenWaitMax=8).
module tb_dat_busy_monitor;

  logic clk;
  logic rst;
  logic sd_strobe;
  logic dat0;
  logic running;
  logic timeout;

  int unsigned n_cmp;
  int unsigned n_bad;

  dat_busy_monitor_if u_if ();

  dat_busy_monitor #(
    .BusyGuard    (2),
    .TokenWaitMax (8)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sd_strobe_i (sd_strobe),
    .dat0_i      (dat0),
    .running_o   (running),
    .timeout_i   (timeout),
    .ctrl_if     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {active, running, done, crc_err, token_err, timeout_err}.
  function automatic logic [31:0] flags();
    return {26'd0, u_if.active, running, u_if.done, u_if.crc_err, u_if.token_err,
            u_if.timeout_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with the opposite DAT0 level (must be ignored), then one strobe.
  task automatic strb(input logic b);
    sd_strobe = 1'b0;
    dat0      = ~b;
    cyc();
    sd_strobe = 1'b1;
    dat0      = b;
    cyc();
    sd_strobe = 1'b0;
  endtask

  task automatic start_seq(input logic busy_only);
    u_if.start     = 1'b1;
    u_if.busy_only = busy_only;
    cyc();
    u_if.start = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    sd_strobe      = 1'b0;
    dat0           = 1'b1;
    timeout        = 1'b0;
    u_if.start     = 1'b0;
    u_if.busy_only = 1'b0;
    u_if.abort     = 1'b0;
    cyc();
    cyc();
    chk("reset_flags", flags(), 32'h00);
    rst = 1'b0;
    cyc();
    chk("idle_flags", flags(), 32'h00);

    // Good token 010, 20 busy strobes, release.
    start_seq(1'b0);
    chk("a_started", flags(), 32'h30);
    strb(1'b1);
    strb(1'b1);
    strb(1'b0);
    strb(1'b0);
    strb(1'b1);
    strb(1'b0);
    strb(1'b1);
    strb(1'b1);  // guard 1, DAT0 high ignored
    strb(1'b1);  // guard 2
    chk("a_guard_ignores_high", flags(), 32'h30);
    for (int i = 0; i < 20; i++) strb(1'b0);
    chk("a_busy_wait", flags(), 32'h30);
    strb(1'b1);
    chk("a_done_ok", flags(), 32'h08);
`ifdef SDHCI_BUSY_CYCLES_EN
    chk("a_busy_cycles", u_if.busy_cycles, 32'd23);
`endif
    cyc();
    chk("a_done_one_cycle", flags(), 32'h00);

    // Negative CRC token 101: done after end bit, busy never entered.
    start_seq(1'b0);
    strb(1'b0);
    strb(1'b1);
    strb(1'b0);
    strb(1'b1);
    chk("b_before_end", flags(), 32'h30);
    strb(1'b1);
    chk("b_crc_err", flags(), 32'h0C);
    cyc();
    chk("b_clear", flags(), 32'h00);

    // R1b: DAT0 held low, timeout at strobe 50 together with DAT0 high.
    start_seq(1'b1);
    chk("c_started", flags(), 32'h30);
    for (int i = 0; i < 49; i++) strb(1'b0);
    sd_strobe = 1'b0;
    cyc();
    sd_strobe = 1'b1;
    dat0      = 1'b1;
    timeout   = 1'b1;
    cyc();
    sd_strobe = 1'b0;
    timeout   = 1'b0;
    chk("c_timeout_wins", flags(), 32'h09);
    cyc();
    chk("c_clear", flags(), 32'h00);

    // Timeout in idle is ignored.
    timeout = 1'b1;
    cyc();
    timeout = 1'b0;
    cyc();
    chk("c_idle_timeout", flags(), 32'h00);

    // No start bit in 8 strobes.
    start_seq(1'b0);
    for (int i = 0; i < 7; i++) strb(1'b1);
    chk("d_wait7", flags(), 32'h30);
    strb(1'b1);
    chk("d_no_start", flags(), 32'h0A);

    // End bit sampled low after a good token.
    cyc();
    start_seq(1'b0);
    strb(1'b0);
    strb(1'b0);
    strb(1'b1);
    strb(1'b0);
    strb(1'b0);
    chk("e_end_bit_low", flags(), 32'h0A);

    // Bad token pattern 110.
    cyc();
    start_seq(1'b0);
    strb(1'b0);
    strb(1'b1);
    strb(1'b1);
    strb(1'b0);
    strb(1'b1);
    chk("f_bad_token", flags(), 32'h0A);

    // Abort in busy: idle next cycle, no done.
    cyc();
    start_seq(1'b1);
    strb(1'b0);
    strb(1'b0);
    strb(1'b0);
    u_if.abort = 1'b1;
    cyc();
    u_if.abort = 1'b0;
    chk("g_abort", flags(), 32'h00);
    cyc();
    chk("g_abort_no_done", flags(), 32'h00);

    // Start outside idle is ignored; start in the done cycle is accepted.
    start_seq(1'b1);
    strb(1'b0);
    start_seq(1'b0);
    strb(1'b0);
    strb(1'b1);
    chk("h_ignored_start", flags(), 32'h08);
    start_seq(1'b1);
    chk("h_back_to_back", flags(), 32'h30);
    strb(1'b0);
    strb(1'b0);
    strb(1'b1);
    chk("h_second_done", flags(), 32'h08);
`ifdef SDHCI_BUSY_CYCLES_EN
    chk("h_busy_cycles", u_if.busy_cycles, 32'd3);
`endif

    // Reset mid-sequence.
    cyc();
    start_seq(1'b0);
    strb(1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("j_reset_mid", flags(), 32'h00);
    cyc();
    chk("j_reset_after", flags(), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
